// File: rtl/stdp_weight_update.sv
// STDP learning stage: walks the winning neuron's synapses, one read and one write each, applying a saturating +/-1 update.
// Latency 2*NUM_INPUTS+1 cycles from start to done (1 cycle with no winner); start while busy is dropped.
module stdp_weight_update #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 8,
  parameter int TIME_PERIOD = 8,
  parameter int WEIGHT_MAX  = 7,
  localparam int TW = $clog2(TIME_PERIOD),
  localparam int WW = $clog2(WEIGHT_MAX + 1),
  localparam int NW = $clog2(NUM_NEURONS) + 1,
  localparam int AW = $clog2(NUM_NEURONS * NUM_INPUTS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     output_spike,
  input  logic [TW-1:0]            output_spike_time,
  input  logic [NW-1:0]            winning_neuron,
  input  logic [NUM_INPUTS-1:0]    input_spike,
  input  logic [NUM_INPUTS*TW-1:0] input_spike_time,
  output logic [AW-1:0]            w_addr,
  input  logic [WW-1:0]            w_rd_data,
  output logic                     w_wr_en,
  output logic [WW-1:0]            w_wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int SW = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  state_t                  state, state_n;
  logic [SW-1:0]           syn_q, syn_n;
  logic                    load;
  logic [NW-1:0]           win_q;
  logic [TW-1:0]           tout_q;
  logic [NUM_INPUTS-1:0]   spk_q;
  logic [NUM_INPUTS*TW-1:0] tin_q;

  logic [AW-1:0]           addr_c;
  logic [TW-1:0]           t_in;
  logic [WW:0]             w_inc;
  logic [WW-1:0]           w_next;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      syn_q  <= '0;
      win_q  <= '0;
      tout_q <= '0;
      spk_q  <= '0;
      tin_q  <= '0;
    end else begin
      state <= state_n;
      syn_q <= syn_n;
      if (load) begin
        win_q  <= winning_neuron;
        tout_q <= output_spike_time;
        spk_q  <= input_spike;
        tin_q  <= input_spike_time;
      end
    end
  end

  assign addr_c = AW'(win_q) * AW'(NUM_INPUTS) + AW'(syn_q);

  // Increment is evaluated one bit wider so the clamp sees the carry instead of a wrapped value.
  always_comb begin
    t_in  = tin_q[syn_q*TW +: TW];
    w_inc = {1'b0, w_rd_data} + (WW+1)'(1);
    if (spk_q[syn_q] && (t_in <= tout_q))
      w_next = (w_inc > (WW+1)'(WEIGHT_MAX)) ? WW'(WEIGHT_MAX) : w_inc[WW-1:0];
    else
      w_next = (w_rd_data == '0) ? '0 : w_rd_data - WW'(1);
  end

  always_comb begin
    state_n   = state;
    syn_n     = syn_q;
    load      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    w_wr_en   = 1'b0;
    w_addr    = '0;
    w_wr_data = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (output_spike && (winning_neuron < NW'(NUM_NEURONS))) begin
            load    = 1'b1;
            syn_n   = '0;
            state_n = READ;
          end else begin
            state_n = FINISH;
          end
        end
      end
      READ: begin
        w_addr  = addr_c;
        state_n = WRITE;
      end
      WRITE: begin
        w_addr    = addr_c;
        w_wr_en   = 1'b1;
        w_wr_data = w_next;
        if (syn_q == SW'(NUM_INPUTS - 1)) begin
          state_n = FINISH;
        end else begin
          syn_n   = syn_q + SW'(1);
          state_n = READ;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Randomized bench for stdp_weight_update: synchronous weight memory plus a per-volley reference model of the update rule.
// Every output check runs through check_eq; writes are matched in order against the model's expected write list.
module tb_stdp_weight_update;

  localparam int NI = 16;
  localparam int NN = 8;
  localparam int TW = 3;
  localparam int WW = 3;
  localparam int NW = 4;
  localparam int AW = 7;
  localparam int WMAX = 7;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              output_spike;
  logic [TW-1:0]     output_spike_time;
  logic [NW-1:0]     winning_neuron;
  logic [NI-1:0]     input_spike;
  logic [NI*TW-1:0]  input_spike_time;
  logic [AW-1:0]     w_addr;
  logic [WW-1:0]     w_rd_data;
  logic              w_wr_en;
  logic [WW-1:0]     w_wr_data;
  logic              busy;
  logic              done;

  stdp_weight_update dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .output_spike(output_spike), .output_spike_time(output_spike_time),
    .winning_neuron(winning_neuron), .input_spike(input_spike),
    .input_spike_time(input_spike_time), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .w_wr_en(w_wr_en), .w_wr_data(w_wr_data), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [WW-1:0] mem   [NN*NI];
  logic [WW-1:0] ref_w [NN*NI];
  logic          pl_en;

  // Weight memory: one-cycle read latency; preload copies the reference image while the DUT is idle.
  always @(posedge clock) begin
    w_rd_data <= mem[w_addr];
    if (pl_en) mem <= ref_w;
    else if (w_wr_en) mem[w_addr] <= w_wr_data;
  end

  typedef struct {int addr; int nw; int old;} wr_t;
  wr_t exp_q[$];

  int vecs = 0;
  int errs = 0;
  int busy_n, done_n;

  task automatic check_eq(input string tag, input int obs, input int exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    wr_t e;
    if (busy) busy_n++;
    if (done) done_n++;
    if (w_wr_en) begin
      check_eq("wr_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("wr_addr", int'(w_addr), e.addr);
        check_eq("wr_data", int'(w_wr_data), e.nw);
      end
    end
  endtask

  task automatic scramble();
    output_spike      = 1'($urandom);
    output_spike_time = TW'($urandom);
    winning_neuron    = NW'($urandom);
    input_spike       = NI'($urandom);
    input_spike_time  = 48'({$urandom(), $urandom()});
  endtask

  task automatic preload();
    @(negedge clock);
    pl_en = 1'b1;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // One volley: drive start in an idle cycle, predict the writes, then watch cycles 1..40.
  task automatic run(input bit osp, input int tout, input int win, input logic [NI-1:0] sp,
                     input logic [NI*TW-1:0] tm, input int restart_at, input int reset_at);
    bit valid;
    int done_at, exp_done, w, nw, ti, a;
    wr_t e;
    @(negedge clock);
    output_spike      = osp;
    output_spike_time = TW'(tout);
    winning_neuron    = NW'(win);
    input_spike       = sp;
    input_spike_time  = tm;
    start             = 1'b1;
    valid = osp && (win < NN);
    if (valid) begin
      for (int i = 0; i < NI; i++) begin
        a  = win * NI + i;
        w  = int'(ref_w[a]);
        ti = int'(tm[i*TW +: TW]);
        if (sp[i] && ti <= tout) nw = (w + 1 > WMAX) ? WMAX : w + 1;
        else                     nw = (w > 0) ? w - 1 : 0;
        exp_q.push_back('{a, nw, w});
        ref_w[a] = WW'(nw);
      end
    end
    exp_done = valid ? 2 * NI + 1 : 1;
    busy_n = 0;
    done_n = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      sample();
      if (done && done_at == 0) done_at = c;
      if (done) break;
      if (c == restart_at) begin
        scramble();
        output_spike   = 1'b1;
        winning_neuron = NW'($urandom_range(0, NN - 1));
        start = 1'b1;
      end else begin
        start = 1'b0;
        scramble();
      end
      if (reset_at != 0 && c == reset_at) reset_n = 1'b0;
      if (reset_at != 0 && c == reset_at + 2) reset_n = 1'b1;
    end
    start = 1'b0;
    if (reset_at != 0) begin
      check_eq("rst_done_cycle", done_at, 0);
      check_eq("rst_done_count", done_n, 0);
      check_eq("rst_busy_cycles", busy_n, reset_at);
      check_eq("rst_aborted_wr", exp_q.size(), NI - reset_at / 2);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        ref_w[e.addr] = WW'(e.old);
      end
    end else begin
      check_eq("done_cycle", done_at, exp_done);
      check_eq("done_count", done_n, 1);
      check_eq("busy_cycles", busy_n, exp_done);
      check_eq("missing_wr", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [NI-1:0]    sp;
    logic [NI*TW-1:0] tm;
    reset_n = 1'b0;
    start   = 1'b0;
    pl_en   = 1'b0;
    scramble();
    for (int a = 0; a < NN * NI; a++) ref_w[a] = WW'($urandom_range(0, WMAX));
    preload();
    repeat (2) @(negedge clock);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_wr_en", int'(w_wr_en), 0);
    check_eq("rst_addr", int'(w_addr), 0);
    check_eq("rst_wr_data", int'(w_wr_data), 0);
    reset_n = 1'b1;

    // Capture: all inputs early, weights 5 -> 6 on neuron 3.
    for (int i = 0; i < NI; i++) ref_w[48 + i] = 3'd5;
    preload();
    run(1'b1, 4, 3, 16'hFFFF, {16{3'd2}}, 0, 0);
    check_eq("capture_w48", int'(mem[48]), 6);
    check_eq("capture_w63", int'(mem[63]), 6);

    // Minus (late input) and backoff (silent input) from weight 3.
    ref_w[0] = 3'd3;
    ref_w[1] = 3'd3;
    preload();
    sp = NI'($urandom);
    sp[0] = 1'b1;
    sp[1] = 1'b0;
    tm = 48'({$urandom(), $urandom()});
    tm[2:0] = 3'd5;
    run(1'b1, 2, 0, sp, tm, 0, 0);
    check_eq("minus_w0", int'(mem[0]), 2);
    check_eq("backoff_w1", int'(mem[1]), 2);

    // Saturation at both ends on neuron 5.
    for (int i = 0; i < 8; i++) ref_w[80 + i] = 3'd7;
    for (int i = 8; i < NI; i++) ref_w[80 + i] = 3'd0;
    preload();
    run(1'b1, 7, 5, 16'h00FF, '0, 0, 0);
    check_eq("sat_hi_w80", int'(mem[80]), 7);
    check_eq("sat_lo_w88", int'(mem[88]), 0);

    // No winner: spike flag low, then out-of-range index.
    run(1'b0, 3, 2, NI'($urandom), 48'({$urandom(), $urandom()}), 0, 0);
    run(1'b1, 3, 8, NI'($urandom), 48'({$urandom(), $urandom()}), 0, 0);

    // Start while busy is dropped; mid-walk reset aborts; fresh volley afterwards.
    run(1'b1, $urandom_range(0, 7), 6, NI'($urandom), 48'({$urandom(), $urandom()}), 10, 0);
    run(1'b1, $urandom_range(0, 7), 7, NI'($urandom), 48'({$urandom(), $urandom()}), 0, 12);
    run(1'b1, $urandom_range(0, 7), 4, NI'($urandom), 48'({$urandom(), $urandom()}), 0, 0);

    // Back-to-back volleys on neurons 1 and 2.
    run(1'b1, $urandom_range(0, 7), 1, NI'($urandom), 48'({$urandom(), $urandom()}), 0, 0);
    run(1'b1, $urandom_range(0, 7), 2, NI'($urandom), 48'({$urandom(), $urandom()}), 0, 0);

    repeat (20) begin
      run(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 9),
          NI'($urandom), 48'({$urandom(), $urandom()}), 0, 0);
    end

    @(negedge clock);
    for (int a = 0; a < NN * NI; a++) check_eq("mem_sweep", int'(mem[a]), int'(ref_w[a]));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/stdp_weight_update.md
# stdp_weight_update

Per-volley STDP learning stage directly downstream of lateral inhibition. After each time period it takes the winning neuron, that neuron's output spike time and the latched input volley. It then walks the winning neuron's synapses one at a time through a single-port weight memory and applies a saturating ±1 weight update. The block is idle while no volley has finished, and raises a one-cycle `done` when the memory is consistent again.

## Interface
- `NUM_INPUTS`, 16: synapses per neuron.
- `NUM_NEURONS`, 8: neurons per layer.
- `TIME_PERIOD`, 8: time steps per volley. TW = $clog2(TIME_PERIOD).
- `WEIGHT_MAX`, 7: maximum weight. WW = $clog2(WEIGHT_MAX+1).
- NW = $clog2(NUM_NEURONS)+1, the winner index width, which matches the lateral inhibition output.
- AW = $clog2(NUM_NEURONS*NUM_INPUTS).

Ports:
- `clock`, input, 1: single clock; all state updates on its rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: single-cycle pulse marking the end of a volley.
- `output_spike`, input, 1: the layer produced a winner this volley.
- `output_spike_time`, input, TW: the winner's spike time.
- `winning_neuron`, input, NW: the winner index.
- `input_spike`, input, NUM_INPUTS: input i spiked this volley.
- `input_spike_time`, input, NUM_INPUTS*TW: flattened time of input i in bits [i*TW +: TW].
- `w_addr`, output, AW: weight memory address, computed as winner*NUM_INPUTS + synapse.
- `w_rd_data`, input, WW: read data, valid exactly one cycle after `w_addr` is presented.
- `w_wr_en`, output, 1: weight memory write strobe.
- `w_wr_data`, output, WW: updated weight.
- `busy`, output, 1: high in every non-IDLE state.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, WRITE, FINISH.
- **IDLE**
  - `start`=0: remain in IDLE.
  - `start`=1 with `output_spike`=1 and `winning_neuron` < NUM_NEURONS:
    - latch all volley inputs into internal registers;
    - set synapse counter `syn` to 0;
    - go to READ.
  - `start`=1 with any other input combination: go to FINISH directly, with no memory access.
- **READ**
  - Drive `w_addr` = latched winner*NUM_INPUTS + `syn`.
  - `w_wr_en`=0.
  - Next state is WRITE.
- **WRITE**
  - Hold the same `w_addr`.
  - `w_wr_en`=1.
  - `w_wr_data` = f(`w_rd_data`), where f is the update rule below.
  - If `syn` == NUM_INPUTS-1, go to FINISH.
  - Otherwise increment `syn` and go to READ.
- **FINISH**
  - `done`=1 for this cycle only.
  - Next state is IDLE.
- Update rule, evaluated on latched values, where t_in is input i's time and t_out is the latched output spike time:
  - Capture: `input_spike[i]`=1 and t_in ≤ t_out. Weight becomes w+1, saturating at WEIGHT_MAX.
  - Minus: `input_spike[i]`=1 and t_in > t_out. Weight becomes w−1, saturating at 0.
  - Backoff: `input_spike[i]`=0. Weight becomes w−1, saturating at 0.
- Arithmetic is unsigned, computed at WW+1 bits and then clamped. Wrap-around is never permitted.
- Only the winning neuron's weights are touched. Every synapse is written, including saturated ones whose value is unchanged.
- `start` asserted while `busy`=1 is ignored and is not queued.
- Input ports are don't-care outside the `start` cycle because the block uses its latched copies.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - state returns to IDLE;
  - `syn`=0 and all latched registers are cleared;
  - `busy`, `done`, `w_wr_en`, `w_addr` and `w_wr_data` are all 0.
- Reset asserted mid-walk aborts the walk immediately:
  - no further writes occur;
  - no `done` pulse is generated;
  - synapses already written keep their new values.
- `w_addr`, `w_wr_en`, `w_wr_data`, `busy` and `done` are decoded from registered state. They are valid in the cycle after the edge that entered that state.
- Update latency: with `start` sampled at edge 0, READ occupies cycle 1 and WRITE occupies cycle 2. The last WRITE is in cycle 2*NUM_INPUTS and `done` is high in cycle 2*NUM_INPUTS+1. For the defaults this is 33 cycles.
- No-update latency: `done` is high in cycle 1.
- `busy` is high from cycle 1 through the cycle in which `done` is high, inclusive.
- Throughput: a new `start` is accepted in the first IDLE cycle after `done`.

## Test plan
1. **Capture.** Winner=3, `output_spike_time`=4, all inputs spiked at t=2, all weights initially 5. Required: 16 writes to addresses 48..63, each with data 6, and `done` at cycle 33.
2. **Minus and backoff.** Winner=0, t_out=2. Input 0 at t=5; input 1 not spiked. Weights are 3. Required: address 0 written with 2, address 1 written with 2.
3. **Saturation.** Capture with w=7 must write 7. Backoff with w=0 must write 0.
4. **No winner.** `start` with `output_spike`=0, and separately `start` with `winning_neuron`=8. Required in both cases: no write, `done` in cycle 1, `busy` high for exactly one cycle.
5. **Busy ignore and mid-walk reset.**
   - A second `start` at cycle 10 produces no extra writes and exactly one `done`.
   - `reset_n`=0 at cycle 12 stops all writes, clears `busy`, and produces no `done`.
   - A fresh `start` after reset completes normally.
6. **Back-to-back volleys.** `start` in the IDLE cycle immediately after `done`, with winner 1 and then winner 2. Required: address ranges 16..31 and then 32..47 are updated, with no gap cycles beyond the FINISH cycle.
